temp_bus_bank: RTL and testbench
================================

// Module: temp_bus_bank
// PURPOSE
//  Bank of NUM_REGS temporary registers on the shared bidirectional data bus
//  (Data) of the processor datapath.
//  - Loads a selected register from the bus, or drives a selected register onto the bus.
//  - Uses a req/ack handshake and a guaranteed bus-release (turnaround) cycle after every drive.
//  - Continuously presents one selectable register to the ULA on saidaUla.
// PARAMETERS
//  Tamanho_Da_Palavra  16  data word width in bits
//  NUM_REGS            4   number of temporary registers (>=2)
//  DRIVE_CYCLES        1   cycles Data is driven per drive request (>=1)
//  SW                  $clog2(NUM_REGS)  select width (derived, not overridable)
// PORTS
//  clk       in     1    system clock, rising edge
//  rst       in     1    synchronous reset, active-high
//  Data      inout  W    shared data bus; W = Tamanho_Da_Palavra
//  req       in     1    operation request, sampled in IDLE only
//  io        in     1    1 = load register from Data, 0 = drive register onto Data
//  sel       in     SW   register index for the requested operation
//  ula_sel   in     SW   register index presented on saidaUla
//  ack       out    1    one-cycle completion pulse
//  busy      out    1    high whenever state != IDLE
//  saidaUla  out    W    registered copy of reg[ula_sel]
// BEHAVIOUR
//  - Reset (rst high at a rising edge):
//    - all regs = 0, state = IDLE, ack = 0, busy = 0, saidaUla = 0.
//    - Data is released (all Z) from the cycle after that edge onward.
//  - States: IDLE, LOAD, DRIVE, TURN. Sel is latched into sel_q on leaving IDLE.
//  - IDLE & req & io=1 -> LOAD.
//    - In LOAD, ack = 1.
//    - At the edge ending LOAD, reg[sel_q] <= Data; then -> IDLE.
//    - Latency: req seen at edge n, Data sampled at edge n+1.
//  - IDLE & req & io=0 -> DRIVE.
//    - Data = reg[sel_q] for exactly DRIVE_CYCLES cycles.
//    - ack = 1 in the last drive cycle.
//    - Then -> TURN.
//  - TURN: Data = Z, busy = 1, ack = 0; next -> IDLE. A new req is accepted one cycle later.
//  - Bus drive enable is decoded from the registered state only.
//    - No combinational path from req/io/sel to Data enable.
//    - Data is Z in IDLE, LOAD and TURN.
//  - req while busy: ignored, not queued. io/sel changes during an operation have no effect.
//  - sel >= NUM_REGS (non-power-of-2 depth): the request completes with normal timing and ack.
//    - LOAD writes nothing.
//    - DRIVE drives all-zero.
//  - ula_sel >= NUM_REGS: saidaUla <= 0.
//  - saidaUla <= reg[ula_sel] every cycle (1-cycle latency).
//    - After a LOAD to reg[ula_sel], the new value appears on saidaUla one cycle after the write edge.
//  - A drive counter runs 0..DRIVE_CYCLES-1 and is cleared on entering DRIVE and on reset.
//  - Reset mid-operation:
//    - abort, no register write, no ack.
//    - FSM goes to IDLE and Data is released after the reset edge.
// TESTING
//  - Reset: hold rst 2 cycles with the bench driving Data=Z -> Data=Z, ack=0, busy=0, saidaUla=0.
//  - Load/readback (W=16): bench drives Data=16'hA5C3, req=1, io=1, sel=2 ->
//    - ack in the next cycle, reg[2]=A5C3.
//    - ula_sel=2 -> saidaUla=A5C3 one cycle after the write.
//  - Drive/turnaround (DRIVE_CYCLES=3): req, io=0, sel=2 ->
//    - Data=A5C3 for 3 cycles, ack in the 3rd.
//    - Then 1 TURN cycle at Z, then IDLE; the bus checker must see no overlap with bench drive.
//  - Back-to-back: hold req=1 with alternating io ->
//    - ops are accepted only in IDLE.
//    - each drive is followed by exactly one Z TURN cycle.
//    - no req is lost or duplicated.
//  - Busy-ignore: pulse req with sel=1 during DRIVE -> reg[1] unchanged, no extra ack.
//  - Reset mid-drive: assert rst in the 2nd DRIVE cycle ->
//    - Data=Z the next cycle, ack=0, all regs = 0.

Source files
------------

// File: rtl/temp_bus_bank.sv
// Bank of temporary registers on the shared bidirectional Data bus.
// A req/ack handshake loads or drives one register; drives end with a bus-release cycle.
module temp_bus_bank #(
  parameter int Tamanho_Da_Palavra = 16,
  parameter int NUM_REGS           = 4,
  parameter int DRIVE_CYCLES       = 1,
  localparam int SW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  inout  wire  [Tamanho_Da_Palavra-1:0] Data,
  input  logic                          req,
  input  logic                          io,
  input  logic [SW-1:0]                 sel,
  input  logic [SW-1:0]                 ula_sel,
  output logic                          ack,
  output logic                          busy,
  output logic [Tamanho_Da_Palavra-1:0] saidaUla
);

  localparam int W  = Tamanho_Da_Palavra;
  localparam int CW = (DRIVE_CYCLES > 1) ? $clog2(DRIVE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DRIVE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'((DRIVE_CYCLES > 1) ? (DRIVE_CYCLES - 2) : 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRIVE = 2'd2,
    ST_TURN  = 2'd3
  } state_t;

  state_t        state_r;
  logic [SW-1:0] sel_r;
  logic [CW-1:0] cnt_r;
  logic [W-1:0]  regs_r [NUM_REGS];
  logic [W-1:0]  drive_r;
  logic          ack_r;
  logic          busy_r;
  logic [W-1:0]  ula_r;
  logic [W-1:0]  sel_val_s;
  logic [W-1:0]  ula_val_s;

  // Read muxes for the request and ULA selects; indices past NUM_REGS read as zero
  always_comb begin
    sel_val_s = {W{1'b0}};
    ula_val_s = {W{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      sel_val_s = (sel == SW'(i)) ? regs_r[i] : sel_val_s;
      ula_val_s = (ula_sel == SW'(i)) ? regs_r[i] : ula_val_s;
    end
  end

  // Handshake FSM, register bank writes and latched drive word
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      sel_r   <= {SW{1'b0}};
      cnt_r   <= {CW{1'b0}};
      drive_r <= {W{1'b0}};
      ack_r   <= 1'b0;
      busy_r  <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {W{1'b0}};
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req) begin
            sel_r  <= sel;
            busy_r <= 1'b1;
            if (io) begin
              state_r <= ST_LOAD;
              ack_r   <= 1'b1;
            end else begin
              // drive word is frozen here; no load can land while driving
              state_r <= ST_DRIVE;
              cnt_r   <= {CW{1'b0}};
              drive_r <= sel_val_s;
              ack_r   <= (DRIVE_CYCLES == 1);
            end
          end
        end
        ST_LOAD: begin
          for (int i = 0; i < NUM_REGS; i++) begin
            if (sel_r == SW'(i)) regs_r[i] <= Data;
          end
          state_r <= ST_IDLE;
          ack_r   <= 1'b0;
          busy_r  <= 1'b0;
        end
        ST_DRIVE: begin
          if (cnt_r == CNT_LAST) begin
            state_r <= ST_TURN;
            ack_r   <= 1'b0;
          end else begin
            cnt_r <= cnt_r + CW'(1);
            ack_r <= (cnt_r == CNT_PRE);
          end
        end
        ST_TURN: begin
          state_r <= ST_IDLE;
          ack_r   <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          ack_r   <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Registered ULA tap, one cycle behind the bank
  always_ff @(posedge clk) begin
    if (rst) begin
      ula_r <= {W{1'b0}};
    end else begin
      ula_r <= ula_val_s;
    end
  end

  assign Data     = (state_r == ST_DRIVE) ? drive_r : {W{1'bz}};
  assign ack      = ack_r;
  assign busy     = busy_r;
  assign saidaUla = ula_r;

endmodule

// File: tb/tb_temp_bus_bank.sv
// Bench for temp_bus_bank: directed vector table, then operation-level model checks.
module tb_temp_bus_bank;

  localparam int W  = 16;
  localparam int NR = 3;
  localparam int DC = 3;

  logic        clk = 1'b0;
  logic        rst, req, io;
  logic [1:0]  sel, ula_sel;
  logic        ack, busy;
  logic [15:0] saidaUla;
  logic        tb_drv;
  logic [15:0] tb_data;
  wire  [15:0] Data;

  assign Data = tb_drv ? tb_data : {16{1'bz}};

  always #5 clk = ~clk;

  temp_bus_bank #(.Tamanho_Da_Palavra(W), .NUM_REGS(NR), .DRIVE_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .Data(Data), .req(req), .io(io), .sel(sel),
    .ula_sel(ula_sel), .ack(ack), .busy(busy), .saidaUla(saidaUla)
  );

  int total = 0;
  int bad   = 0;

  // one expected bus cycle of an accepted operation
  typedef struct packed {
    logic        busy;
    logic        ack;
    logic        drv;
    logic [15:0] val;
    logic        ld;
    logic [1:0]  sel;
  } slot_t;

  slot_t       q[$];
  slot_t       cur;
  logic [15:0] m_regs [NR];
  logic [15:0] exp_ula;

  typedef struct {
    logic        r, rq, io;
    logic [1:0]  sel, ula;
    logic        bd;
    logic [15:0] bv;
    logic        e_busy, e_ack, e_drv;
    logic [15:0] e_dat, e_ula;
  } vec_t;

  localparam int NROWS = 23;
  vec_t tbl [NROWS];

  function automatic vec_t mk(input logic r, rq, i, input logic [1:0] s, u,
                              input logic bd, input logic [15:0] bv,
                              input logic eb, ea, ed, input logic [15:0] edat, eula);
    vec_t v;
    v.r = r; v.rq = rq; v.io = i; v.sel = s; v.ula = u; v.bd = bd; v.bv = bv;
    v.e_busy = eb; v.e_ack = ea; v.e_drv = ed; v.e_dat = edat; v.e_ula = eula;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Operation-level model: an accepted request becomes a list of expected bus cycles
  task automatic model_edge(input logic r, rq, i, input logic [1:0] s, u, input logic [15:0] bus);
    slot_t       sl;
    logic [15:0] v;
    if (!r && int'(u) < NR) exp_ula = m_regs[u];
    else exp_ula = 16'h0000;
    if (r) begin
      q.delete();
      for (int k = 0; k < NR; k++) m_regs[k] = 16'h0000;
    end else if (q.size() != 0) begin
      sl = q.pop_front();
      if (sl.ld && int'(sl.sel) < NR) m_regs[sl.sel] = bus;
    end else if (rq) begin
      if (i) begin
        sl = '0; sl.busy = 1'b1; sl.ack = 1'b1; sl.ld = 1'b1; sl.sel = s;
        q.push_back(sl);
      end else begin
        if (int'(s) < NR) v = m_regs[s];
        else v = 16'h0000;
        for (int k = 0; k < DC; k++) begin
          sl = '0; sl.busy = 1'b1; sl.drv = 1'b1; sl.val = v; sl.ack = (k == DC - 1);
          q.push_back(sl);
        end
        sl = '0; sl.busy = 1'b1;
        q.push_back(sl);
      end
    end
    cur = (q.size() != 0) ? q[0] : '0;
  endtask

  task automatic tick(input logic r, rq, i, input logic [1:0] s, u);
    logic [15:0] seen;
    rst = r; req = rq; io = i; sel = s; ula_sel = u;
    seen = tb_drv ? tb_data : 16'h0000;
    @(posedge clk);
    #1;
    model_edge(r, rq, i, s, u, seen);
  endtask

  task automatic mstep(input logic r, rq, i, input logic [1:0] s, u);
    tick(r, rq, i, s, u);
    tb_drv  = !cur.drv;
    tb_data = 16'($urandom) | 16'h0001;
    #1;
    chk("m_busy", {15'd0, busy}, {15'd0, cur.busy});
    chk("m_ack", {15'd0, ack}, {15'd0, cur.ack});
    chk("m_ula", saidaUla, exp_ula);
    chk("m_data", Data, cur.drv ? cur.val : tb_data);
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; io = 1'b0; sel = 2'd0; ula_sel = 2'd0;
    tb_drv = 1'b0; tb_data = 16'h0000;
    for (int k = 0; k < NR; k++) m_regs[k] = 16'h0000;
    cur = '0;

    //           r  rq io sel ula  bd bv        busy ack drv dat       ula
    tbl[0]  = mk(1, 0, 0, 0, 0,   0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000);
    tbl[1]  = mk(1, 0, 0, 0, 0,   1, 16'h1234, 0, 0, 0, 16'h0000, 16'h0000);
    tbl[2]  = mk(0, 1, 1, 2, 2,   1, 16'hA5C3, 1, 1, 0, 16'h0000, 16'h0000);
    tbl[3]  = mk(0, 0, 0, 0, 2,   1, 16'hFFFF, 0, 0, 0, 16'h0000, 16'h0000);
    tbl[4]  = mk(0, 0, 0, 0, 2,   1, 16'h0000, 0, 0, 0, 16'h0000, 16'hA5C3);
    tbl[5]  = mk(0, 1, 0, 2, 2,   0, 16'h0000, 1, 0, 1, 16'hA5C3, 16'hA5C3);
    tbl[6]  = mk(0, 0, 0, 0, 2,   0, 16'h0000, 1, 0, 1, 16'hA5C3, 16'hA5C3);
    tbl[7]  = mk(0, 0, 0, 0, 2,   0, 16'h0000, 1, 1, 1, 16'hA5C3, 16'hA5C3);
    tbl[8]  = mk(0, 0, 0, 0, 2,   1, 16'h0F0F, 1, 0, 0, 16'h0000, 16'hA5C3);
    tbl[9]  = mk(0, 0, 0, 0, 2,   1, 16'h0F0F, 0, 0, 0, 16'h0000, 16'hA5C3);
    tbl[10] = mk(0, 1, 0, 2, 1,   0, 16'h0000, 1, 0, 1, 16'hA5C3, 16'h0000);
    tbl[11] = mk(0, 1, 1, 1, 1,   0, 16'h0000, 1, 0, 1, 16'hA5C3, 16'h0000);
    tbl[12] = mk(0, 0, 0, 0, 1,   0, 16'h0000, 1, 1, 1, 16'hA5C3, 16'h0000);
    tbl[13] = mk(0, 1, 1, 1, 1,   1, 16'h5555, 1, 0, 0, 16'h0000, 16'h0000);
    tbl[14] = mk(0, 0, 0, 0, 1,   1, 16'h5555, 0, 0, 0, 16'h0000, 16'h0000);
    tbl[15] = mk(0, 0, 0, 0, 1,   1, 16'h0001, 0, 0, 0, 16'h0000, 16'h0000);
    tbl[16] = mk(0, 1, 1, 3, 3,   1, 16'hBEEF, 1, 1, 0, 16'h0000, 16'h0000);
    tbl[17] = mk(0, 0, 0, 0, 0,   1, 16'h1111, 0, 0, 0, 16'h0000, 16'h0000);
    tbl[18] = mk(0, 1, 0, 3, 2,   0, 16'h0000, 1, 0, 1, 16'h0000, 16'hA5C3);
    tbl[19] = mk(0, 0, 0, 0, 1,   0, 16'h0000, 1, 0, 1, 16'h0000, 16'h0000);
    tbl[20] = mk(0, 0, 0, 0, 0,   0, 16'h0000, 1, 1, 1, 16'h0000, 16'h0000);
    tbl[21] = mk(0, 0, 0, 0, 3,   1, 16'h2222, 1, 0, 0, 16'h0000, 16'h0000);
    tbl[22] = mk(0, 0, 0, 0, 2,   1, 16'h2222, 0, 0, 0, 16'h0000, 16'hA5C3);

    for (int n = 0; n < NROWS; n++) begin
      tick(tbl[n].r, tbl[n].rq, tbl[n].io, tbl[n].sel, tbl[n].ula);
      tb_drv  = tbl[n].bd;
      tb_data = tbl[n].bv;
      #1;
      chk($sformatf("vec%0d_busy", n), {15'd0, busy}, {15'd0, tbl[n].e_busy});
      chk($sformatf("vec%0d_ack", n), {15'd0, ack}, {15'd0, tbl[n].e_ack});
      chk($sformatf("vec%0d_ula", n), saidaUla, tbl[n].e_ula);
      if (tbl[n].e_drv || tbl[n].bd)
        chk($sformatf("vec%0d_data", n), Data, tbl[n].e_drv ? tbl[n].e_dat : tbl[n].bv);
    end

    // back-to-back: req held high, io alternating
    mstep(1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
    for (int k = 0; k < 30; k++)
      mstep(1'b0, 1'b1, k[0], 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));

    // reset in the second drive cycle
    mstep(1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
    mstep(1'b0, 1'b1, 1'b1, 2'd0, 2'd0);
    mstep(1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    mstep(1'b0, 1'b1, 1'b0, 2'd0, 2'd0);
    mstep(1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    mstep(1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
    chk("rstmid_busy", {15'd0, busy}, 16'h0000);
    chk("rstmid_ack", {15'd0, ack}, 16'h0000);
    for (int k = 0; k < NR; k++) begin
      mstep(1'b0, 1'b0, 1'b0, 2'd0, 2'(k));
    end
    mstep(1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    chk("rstmid_reg2", saidaUla, 16'h0000);

    // randomized traffic
    for (int k = 0; k < 800; k++)
      mstep(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) != 0), 1'($urandom),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
